// File: rtl/multicycle_controller_pkg.sv
// Shared opcodes, ALU op classes, ALU control codes and FSM state encodings for the multicycle controller.
// Latency: none (declarations and a pure combinational helper).
// Backpressure: not applicable.
package multicycle_controller_pkg;

  // Supported RV32I opcodes
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALU operation class chosen by the FSM
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Operation codes understood by the shared alu
  localparam logic [2:0] ALU_CTRL_ADD = 3'b000;
  localparam logic [2:0] ALU_CTRL_SUB = 3'b001;
  localparam logic [2:0] ALU_CTRL_AND = 3'b010;
  localparam logic [2:0] ALU_CTRL_OR  = 3'b011;
  localparam logic [2:0] ALU_CTRL_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  // Immediate format from opcode; unknown opcodes fall back to I-format
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src_of = 2'b01;
      OP_BEQ:  imm_src_of = 2'b10;
      OP_JAL:  imm_src_of = 2'b11;
      default: imm_src_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Maps the FSM's ALU operation class plus funct fields to an ALU control code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALUControl
);

  // funct3 decode only matters for R/I arithmetic; sub needs R-type with instr[30] set
  always_comb begin
    ALUControl = ALU_CTRL_ADD;
    case (alu_op)
      ALUOP_ADD: ALUControl = ALU_CTRL_ADD;
      ALUOP_SUB: ALUControl = ALU_CTRL_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  ALUControl = (op5 & funct7b5) ? ALU_CTRL_SUB : ALU_CTRL_ADD;
          3'b010:  ALUControl = ALU_CTRL_SLT;
          3'b110:  ALUControl = ALU_CTRL_OR;
          3'b111:  ALUControl = ALU_CTRL_AND;
          default: ALUControl = ALU_CTRL_ADD;
        endcase
      end
      default: ALUControl = ALU_CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RV32I datapath, with ImmSrc decode and retired-instruction counter.
// Latency: lw 5, sw/R/I/jal 4, beq 3, illegal 2 cycles with no memory stalls.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold (selects stable) until mem_ready.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUControl,
  output logic        illegal,
  output logic [31:0] instret
);

  state_t     state, state_nxt;
  logic [1:0] alu_op;
  logic       pc_write_d, mem_write_d, ir_write_d, reg_write_d, illegal_d;
  logic       retire;

  // State register; reset parks the FSM in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state and Moore outputs (qualified by mem_ready / Zero / op where needed)
  always_comb begin
    state_nxt   = state;
    alu_op      = ALUOP_ADD;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    pc_write_d  = 1'b0;
    mem_write_d = 1'b0;
    ir_write_d  = 1'b0;
    reg_write_d = 1'b0;
    illegal_d   = 1'b0;
    retire      = 1'b0;
    case (state)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          ir_write_d = 1'b1;
          pc_write_d = 1'b1;
          state_nxt  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/jal target precomputed from OldPC + imm into ALUOut
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECUTER;
          OP_I:         state_nxt = S_EXECUTEI;
          OP_JAL:       state_nxt = S_JAL;
          OP_BEQ:       state_nxt = S_BEQ;
          default: begin
            illegal_d = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        state_nxt = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_d = 1'b1;
        retire      = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_d = mem_ready;
        if (mem_ready) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXECUTER: begin
        ALUSrcA   = 2'b10;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_d = 1'b1;
        retire      = 1'b1;
        state_nxt   = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        pc_write_d = 1'b1;
        state_nxt  = S_ALUWB;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        alu_op     = ALUOP_SUB;
        pc_write_d = Zero;
        retire     = 1'b1;
        state_nxt  = S_FETCH;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // Write strobes are masked during reset so FETCH's mem_ready qualifier cannot leak a pulse
  assign PCWrite  = pc_write_d  & rst_n;
  assign MemWrite = mem_write_d & rst_n;
  assign IRWrite  = ir_write_d  & rst_n;
  assign RegWrite = reg_write_d & rst_n;
  assign illegal  = illegal_d   & rst_n;
  assign ImmSrc   = imm_src_of(op);

  // Retired-instruction counter, wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret <= 32'd0;
    else if (retire) instret <= instret + 32'd1;
  end

  alu_decoder u_alu_decoder (
    .alu_op     (alu_op),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller with hand-computed control words.
// Latency: checks each state one cycle apart, sampled just after the falling edge.
// Backpressure: exercises mem_ready stalls in FETCH, MEMREAD and MEMWRITE.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        Zero;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic        illegal;
  logic [31:0] instret;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011, BAD = 7'b0000000;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .illegal(illegal), .instret(instret)
  );

  // Control word: pcw adr mw irw rw | rs[2] sa[2] sb[2] imm[2] alu[3]
  logic [15:0] ctl;
  assign ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

  function automatic logic [15:0] mk(input logic [4:0] en, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] imm, input logic [2:0] alu);
    return {en, rs, sa, sb, imm, alu};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One state: drive inputs on the falling edge, then check the control word
  task automatic cyc(input string tag, input logic [6:0] o, input logic mr, input logic z, input logic [15:0] exp);
    @(negedge clk);
    op = o; mem_ready = mr; Zero = z;
    #1;
    check_val(tag, {16'h0, ctl}, {16'h0, exp});
  endtask

  initial begin
    rst_n = 1'b0; op = RT; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;

    // Reset: enables masked even with mem_ready high, FETCH selects shown
    @(negedge clk); #1;
    check_val("reset_ctl", {16'h0, ctl}, {16'h0, mk(5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000)});
    check_val("reset_instret", instret, 32'd0);
    check_val("reset_illegal", {31'd0, illegal}, 32'd0);

    // add
    rst_n = 1'b1; #1;
    check_val("add_fetch", {16'h0, ctl}, {16'h0, mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000)});
    cyc("add_decode", RT, 1, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
    check_val("add_decode_illegal", {31'd0, illegal}, 32'd0);
    cyc("add_exec", RT, 1, 0, mk(5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b000));
    cyc("add_wb", RT, 1, 0, mk(5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    check_val("add_wb_instret", instret, 32'd0);

    // sub
    funct7b5 = 1'b1;
    cyc("sub_fetch", RT, 1, 0, mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    check_val("add_instret", instret, 32'd1);
    cyc("sub_decode", RT, 1, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
    cyc("sub_exec", RT, 1, 0, mk(5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001));
    cyc("sub_wb", RT, 1, 0, mk(5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    funct7b5 = 1'b0;

    // lw with 3 MEMREAD stalls: 8 cycles
    cyc("lw_fetch", LW, 1, 0, mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    check_val("sub_instret", instret, 32'd2);
    cyc("lw_decode", LW, 1, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
    cyc("lw_memadr", LW, 1, 0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
    for (int i = 0; i < 3; i++)
      cyc($sformatf("lw_stall%0d", i), LW, 0, 0, mk(5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    cyc("lw_memread", LW, 1, 0, mk(5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    cyc("lw_memwb", LW, 1, 0, mk(5'b00001, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000));
    check_val("lw_memwb_instret", instret, 32'd2);

    // beq taken
    cyc("beq1_fetch", BQ, 1, 1, mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000));
    check_val("lw_instret", instret, 32'd3);
    cyc("beq1_decode", BQ, 1, 1, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000));
    cyc("beq1_beq", BQ, 1, 1, mk(5'b10000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));

    // beq not taken
    cyc("beq0_fetch", BQ, 1, 0, mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000));
    check_val("beq1_instret", instret, 32'd4);
    cyc("beq0_decode", BQ, 1, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000));
    cyc("beq0_beq", BQ, 1, 0, mk(5'b00000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));

    // jal
    cyc("jal_fetch", JL, 1, 0, mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000));
    check_val("beq0_instret", instret, 32'd5);
    cyc("jal_decode", JL, 1, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000));
    cyc("jal_jal", JL, 1, 0, mk(5'b10000, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000));
    cyc("jal_wb", JL, 1, 0, mk(5'b00001, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000));

    // sw with one FETCH stall and one MEMWRITE stall
    cyc("sw_fetch_stall", SW, 0, 0, mk(5'b00000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000));
    check_val("jal_instret", instret, 32'd6);
    cyc("sw_fetch", SW, 1, 0, mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000));
    cyc("sw_decode", SW, 1, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000));
    cyc("sw_memadr", SW, 1, 0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000));
    cyc("sw_write_stall", SW, 0, 0, mk(5'b01000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000));
    check_val("sw_stall_instret", instret, 32'd6);
    cyc("sw_write", SW, 1, 0, mk(5'b01100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000));

    // illegal opcode
    cyc("ill_fetch", BAD, 1, 0, mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    check_val("sw_instret", instret, 32'd7);
    cyc("ill_decode", BAD, 1, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
    check_val("ill_pulse", {31'd0, illegal}, 32'd1);

    // addi with instr[30] set must still add (I-type)
    funct7b5 = 1'b1;
    cyc("addi_fetch", IT, 1, 0, mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    check_val("ill_pulse_end", {31'd0, illegal}, 32'd0);
    check_val("ill_instret", instret, 32'd7);
    cyc("addi_decode", IT, 1, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
    cyc("addi_exec", IT, 1, 0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
    cyc("addi_wb", IT, 1, 0, mk(5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    funct7b5 = 1'b0;

    // ori / andi / slti execute codes
    funct3 = 3'b110;
    cyc("ori_fetch", IT, 1, 0, mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    check_val("addi_instret", instret, 32'd8);
    cyc("ori_decode", IT, 1, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
    cyc("ori_exec", IT, 1, 0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011));
    funct3 = 3'b111; #1;
    check_val("andi_exec", {29'd0, ALUControl}, {29'd0, 3'b010});
    funct3 = 3'b010; #1;
    check_val("slti_exec", {29'd0, ALUControl}, {29'd0, 3'b101});
    funct3 = 3'b001; #1;
    check_val("other_f3_exec", {29'd0, ALUControl}, {29'd0, 3'b000});
    funct3 = 3'b000;
    cyc("ori_wb", IT, 1, 0, mk(5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));

    // lw stalled in MEMREAD, then reset mid-stall
    cyc("lw2_fetch", LW, 1, 0, mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    cyc("lw2_decode", LW, 1, 0, mk(5'b00000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
    cyc("lw2_memadr", LW, 1, 0, mk(5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
    cyc("lw2_stall", LW, 0, 0, mk(5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    check_val("lw2_pre_rst_instret", instret, 32'd9);
    rst_n = 1'b0; mem_ready = 1'b1; #1;
    check_val("midrst_ctl", {16'h0, ctl}, {16'h0, mk(5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000)});
    check_val("midrst_instret", instret, 32'd0);
    @(negedge clk); #1;
    check_val("midrst_hold", {16'h0, ctl}, {16'h0, mk(5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000)});
    rst_n = 1'b1; #1;
    check_val("post_rst_fetch", {16'h0, ctl}, {16'h0, mk(5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000)});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
